add_sequencer: RTL and testbench



---
 rtl/add_seq_pkg.sv | 8 +
 rtl/add_sequencer_if.sv | 31 +++
 rtl/adder_4_bits.sv | 12 +
 rtl/add_sequencer.sv | 85 ++++++++
 tb/tb_add_sequencer.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/add_seq_pkg.sv
// add_seq_pkg: shared state encoding, nibble width and index-width helper for add_sequencer.
package add_seq_pkg;
    typedef enum logic {IDLE, RUN} state_t;
    localparam int NIBBLE_W = 4;
    function automatic int idx_width(input int nibbles);
        return (nibbles > 1) ? $clog2(nibbles) : 1;
    endfunction
endpackage

// File: rtl/add_sequencer_if.sv
// add_sequencer_if: start/busy/done request bus for add_sequencer; sub exists only with ADD_SEQ_SUB_EN.
interface add_sequencer_if
    import add_seq_pkg::*;
#(parameter int WIDTH = 16);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
`ifdef ADD_SEQ_SUB_EN
    logic             sub;
`endif
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             busy;
    logic             done;
    modport master (
        output start, a, b, cin,
`ifdef ADD_SEQ_SUB_EN
        output sub,
`endif
        input  sum, cout, ovf, busy, done
    );
    modport slave (
        input  start, a, b, cin,
`ifdef ADD_SEQ_SUB_EN
        input  sub,
`endif
        output sum, cout, ovf, busy, done
    );
endinterface

// File: rtl/adder_4_bits.sv
// adder_4_bits: combinational 4-bit ripple adder with carry in/out.
module adder_4_bits
    import add_seq_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                cin,
    output logic [NIBBLE_W-1:0] s,
    output logic                cout
);
    assign {cout, s} = {1'b0, a} + {1'b0, b} + {{NIBBLE_W{1'b0}}, cin};
endmodule

// File: rtl/add_sequencer.sv
// add_sequencer: WIDTH-bit add sequenced one nibble per cycle through a shared adder_4_bits;
// define ADD_SEQ_SUB_EN to add the sub port (B inverted, carry forced to 1).
module add_sequencer
    import add_seq_pkg::*;
#(parameter int WIDTH = 16) (
    input logic            clk,
    input logic            rst,
    add_sequencer_if.slave bus
);
    localparam int NIBBLES = WIDTH / NIBBLE_W;
    localparam int IW      = idx_width(NIBBLES);

    state_t               state, state_n;
    logic [IW-1:0]        idx;
    logic                 carry;
    logic [WIDTH-1:0]     a_q, b_q, sum_q;
    logic                 cout_q, ovf_q, done_q;
    logic [NIBBLE_W-1:0]  nib_s;
    logic                 nib_c, last, accept, sub_sel;

`ifdef ADD_SEQ_SUB_EN
    assign sub_sel = bus.sub;
`else
    assign sub_sel = 1'b0;
`endif

    assign last   = idx == IW'(NIBBLES - 1);
    assign accept = (state == IDLE) && bus.start;

    adder_4_bits u_adder (
        .a   (a_q[NIBBLE_W*idx +: NIBBLE_W]),
        .b   (b_q[NIBBLE_W*idx +: NIBBLE_W]),
        .cin (carry),
        .s   (nib_s),
        .cout(nib_c)
    );

    always_comb begin
        state_n = accept ? RUN : (state == RUN && last) ? IDLE : state;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx    <= '0;
            carry  <= 1'b0;
            a_q    <= '0;
            b_q    <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (accept) begin
                a_q    <= bus.a;
                b_q    <= sub_sel ? ~bus.b : bus.b;
                carry  <= sub_sel ? 1'b1 : bus.cin;
                idx    <= '0;
                sum_q  <= '0;
                cout_q <= 1'b0;
                ovf_q  <= 1'b0;
            end else if (state == RUN) begin
                sum_q[NIBBLE_W*idx +: NIBBLE_W] <= nib_s;
                carry <= nib_c;
                idx   <= last ? '0 : idx + IW'(1);
                if (last) begin
                    cout_q <= nib_c;
                    ovf_q  <= (a_q[WIDTH-1] == b_q[WIDTH-1]) && (nib_s[NIBBLE_W-1] != a_q[WIDTH-1]);
                    done_q <= 1'b1;
                end
            end
        end
    end

    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
    assign bus.ovf  = ovf_q;
    assign bus.busy = state == RUN;
    assign bus.done = done_q;
endmodule

// File: tb/tb_add_sequencer.sv
// tb_add_sequencer: randomized and directed checks of add_sequencer against an arithmetic reference model.
module tb_add_sequencer;
    localparam int W = 16;
    localparam int N = W / 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    add_sequencer_if #(.WIDTH(W)) bus();
    add_sequencer_if #(.WIDTH(8)) bus8();

    add_sequencer #(.WIDTH(W)) dut  (.clk(clk), .rst(rst), .bus(bus));
    add_sequencer #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));

    int tests = 0;
    int fails = 0;
    logic [W+1:0] last_exp;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Returns {ovf, cout, sum} from plain integer arithmetic on the operands.
    function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic c, input logic s);
        longint m, ux, uy, uc, ut, sx, sy, st;
        logic [W+1:0] r;
        m  = longint'(1) << W;
        ux = longint'(x);
        uy = s ? (m - 1 - longint'(y)) : longint'(y);
        uc = s ? 1 : longint'(c);
        ut = ux + uy + uc;
        sx = (ux >= m / 2) ? ux - m : ux;
        sy = (uy >= m / 2) ? uy - m : uy;
        st = sx + sy + uc;
        r[W-1:0] = W'(ut % m);
        r[W]     = ut >= m;
        r[W+1]   = (st >= m / 2) || (st < -(m / 2));
        return r;
    endfunction

    // mode 0: single start pulse; 1: start held through done; 2: stray start with new operands mid-run
    task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic c,
                         input logic s, input int mode);
        int busy_n, done_n, done_at;
        last_exp = model(x, y, c, s);
        bus.start = 1'b1;
        bus.a = x;
        bus.b = y;
        bus.cin = c;
`ifdef ADD_SEQ_SUB_EN
        bus.sub = s;
`endif
        busy_n = 0;
        done_n = 0;
        done_at = -1;
        for (int k = 0; k <= N; k++) begin
            @(negedge clk);
            if (bus.busy) busy_n++;
            if (bus.done) begin
                done_n++;
                if (done_at < 0) done_at = k;
            end
            if (mode != 1 && k == 0) bus.start = 1'b0;
            if (mode == 2 && k == 1) begin
                bus.start = 1'b1;
                bus.a = W'($urandom);
                bus.b = W'($urandom);
                bus.cin = 1'($urandom);
            end
            if (mode == 2 && k == 2) bus.start = 1'b0;
        end
        check("busy_cycles", busy_n, N);
        check("done_count", done_n, 1);
        check("done_edge", done_at, N);
        check("sum", bus.sum, last_exp[W-1:0]);
        check("cout", bus.cout, last_exp[W]);
        check("ovf", bus.ovf, last_exp[W+1]);
    endtask

    initial begin
        int dn;
        int mode;
        logic [W-1:0] x, y;
        logic c, s;
        rst = 1'b1;
        bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0;
        bus8.start = 1'b0; bus8.a = '0; bus8.b = '0; bus8.cin = 1'b0;
`ifdef ADD_SEQ_SUB_EN
        bus.sub = 1'b0;
        bus8.sub = 1'b0;
`endif
        repeat (2) @(negedge clk);
        check("rst_sum", bus.sum, 0);
        check("rst_cout", bus.cout, 0);
        check("rst_ovf", bus.ovf, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        rst = 1'b0;
        @(negedge clk);

        do_op(16'h1234, 16'h0FCD, 1'b0, 1'b0, 0);
        check("tp_sum_2201", bus.sum, 16'h2201);
        do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0);
        check("tp_wrap_cout", bus.cout, 1);
        do_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 0);
        check("tp_ovf_sum", bus.sum, 16'h8000);
        check("tp_ovf", bus.ovf, 1);
        do_op(16'h4321, 16'h1111, 1'b1, 1'b0, 2);
        check("stray_start_sum", bus.sum, 16'h5433);
        @(negedge clk);
        check("stray_not_queued", bus.busy, 0);
        check("done_one_cycle", bus.done, 0);
        check("sum_hold", bus.sum, 16'h5433);
        do_op(16'h00F0, 16'h0F10, 1'b0, 1'b0, 1);
        do_op(16'h8000, 16'h8000, 1'b0, 1'b0, 0);

        // reset in the middle of a run
        bus.start = 1'b1; bus.a = 16'hAAAA; bus.b = 16'h5555; bus.cin = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst_busy", bus.busy, 0);
        check("midrst_sum", bus.sum, 0);
        check("midrst_done", bus.done, 0);
        @(negedge clk);
        rst = 1'b0;
        dn = 0;
        for (int k = 0; k < N + 2; k++) begin
            @(negedge clk);
            if (bus.done) dn++;
        end
        check("midrst_no_done", dn, 0);
        do_op(16'h0001, 16'h0001, 1'b0, 1'b0, 0);
        check("after_rst_sum", bus.sum, 16'h0002);

`ifdef ADD_SEQ_SUB_EN
        do_op(16'h0005, 16'h0007, 1'b0, 1'b1, 0);
        check("sub_sum", bus.sum, 16'hFFFE);
        check("sub_borrow", bus.cout, 0);
        do_op(16'h8000, 16'h0001, 1'b0, 1'b1, 0);
        check("sub_ovf_sum", bus.sum, 16'h7FFF);
        check("sub_ovf", bus.ovf, 1);
`endif

        // narrow instance
        bus8.start = 1'b1; bus8.a = 8'h9C; bus8.b = 8'h64; bus8.cin = 1'b1;
        @(negedge clk);
        bus8.start = 1'b0;
        check("w8_busy0", bus8.busy, 1);
        @(negedge clk);
        check("w8_done_early", bus8.done, 0);
        @(negedge clk);
        check("w8_done", bus8.done, 1);
        check("w8_busy_end", bus8.busy, 0);
        check("w8_sum", bus8.sum, 8'h01);
        check("w8_cout", bus8.cout, 1);

        for (int i = 0; i < 40; i++) begin
            x = W'($urandom);
            y = W'($urandom);
            c = 1'($urandom);
`ifdef ADD_SEQ_SUB_EN
            s = 1'($urandom);
`else
            s = 1'b0;
`endif
            mode = (i == 39) ? 0 : int'($urandom_range(0, 2));
            do_op(x, y, c, s, mode);
            if (mode != 1 && $urandom_range(0, 1) == 1) begin
                @(negedge clk);
                check("gap_done_low", bus.done, 0);
                check("gap_sum_hold", bus.sum, last_exp[W-1:0]);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, tests %0d failed %0d", tests, fails);
        $fatal(1);
    end
endmodule
